corner_scan_ctrl: RTL and testbench
===================================

CORNER_SCAN_CTRL -- requirements
Module: corner_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 64: frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 64: frame height in pixels.
REQ-003 SHALL have parameter WIN, default 6: window edge in pixels.
REQ-004 SHALL have parameter PIPE_LAT, default 4: fixed cycles from win_valid to matching r_in.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8 (power of two): corner FIFO entries.
REQ-006 SHALL have port clk  input  1: single clock, rising edge.
REQ-007 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1: one-cycle frame start request.
REQ-009 SHALL have port thresh  input  64: signed Harris threshold.
REQ-010 SHALL have port win_ready  input  1: window buffer holds valid window at (win_x, win_y).
REQ-011 SHALL have port win_valid  output  1: issue current window to gradient/Harris pipeline.
REQ-012 SHALL have ports win_x, win_y  output  16 each: window origin column and row.
REQ-013 SHALL have port r_in  input  64: signed Harris score R from pipeline.
REQ-014 SHALL have ports corner_valid  output  1, corner_ready  input  1, corner_x/corner_y  output  16 each: corner FIFO head.
REQ-015 SHALL have ports busy  output  1 and done  output  1 (one-cycle pulse).

Function
REQ-016 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-017 IDLE->SCAN on start; win_x=win_y=0 on entry; start ignored outside IDLE.
REQ-018 win_valid SHALL be high iff state==SCAN, win_ready=1, and (fifo_count + inflight) < FIFO_DEPTH (credit rule: FIFO never overflows).
REQ-019 On each issued window, win_x SHALL increment; at IMG_W-WIN wrap to 0 and increment win_y.
REQ-020 Issue of window (IMG_W-WIN, IMG_H-WIN) SHALL transition SCAN->DRAIN.
REQ-021 A PIPE_LAT-deep delay line SHALL carry valid+coords of each issued window; r_in sampled when delayed valid emerges (cycle t+PIPE_LAT for issue at t).
REQ-022 Corner condition: $signed(r_in) > $signed(thresh), strict; equal is not a corner.
REQ-023 A corner SHALL be pushed at that edge; corner_valid high the next cycle (t+PIPE_LAT+1) if FIFO was empty.
REQ-024 Pop on corner_valid && corner_ready; simultaneous push and pop leaves count unchanged; FIFO order preserved.
REQ-025 DRAIN->DONE when inflight==0 and FIFO empty; DONE lasts one cycle asserting done, then IDLE.
REQ-026 busy SHALL be high in SCAN, DRAIN, DONE.
REQ-027 win_x/win_y SHALL hold value while win_valid is low.

Reset
REQ-028 reset SHALL asynchronously force IDLE, win_x=win_y=0, delay line cleared, FIFO emptied.
REQ-029 Outputs during reset: win_valid=0, corner_valid=0, busy=0, done=0, corner_x=corner_y=0.
REQ-030 Reset mid-frame SHALL discard in-flight scores; no corner output until next start.

Configuration
REQ-031 With CORNER_COUNT_EN defined, SHALL add output corner_count (32) counting pushed corners, cleared on reset and on start acceptance, held after DONE.
REQ-032 Without CORNER_COUNT_EN, corner_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 IMG_W=IMG_H=8, WIN=6, win_ready=1, corner_ready=1, start -> exactly 9 win_valid pulses, origins (0,0),(1,0),(2,0),(0,1)..(2,2), done once.
REQ-034 thresh=65536, r_in=65537 on window (1,1) only -> one corner (1,1), corner_valid at issue+PIPE_LAT+1; r_in=65536 -> no corner.
REQ-035 r_in always 70000, corner_ready=0 -> win_valid stops after 8 issues total (FIFO_DEPTH); release corner_ready -> scan resumes, 9 corners output in order.
REQ-036 win_ready toggling 1-0 each cycle -> window order unchanged, win_x/win_y held while low.
REQ-037 reset asserted during DRAIN with 2 in-flight -> next cycle busy=0, corner_valid=0; new start yields full correct frame.
REQ-038 CORNER_COUNT_EN defined, 5 corners per frame, two frames -> corner_count=5 after each done.

Source files
------------

// File: rtl/corner_scan_ctrl.sv
// Corner scan controller: raster window issue, credit-limited score pipeline, corner FIFO.
// Optional corner counter output enabled by defining CORNER_COUNT_EN.
module corner_scan_ctrl #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int WIN        = 6,
    parameter int PIPE_LAT   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] thresh,
    input  logic        win_ready,
    output logic        win_valid,
    output logic [15:0] win_x,
    output logic [15:0] win_y,
    input  logic [63:0] r_in,
    output logic        corner_valid,
    input  logic        corner_ready,
    output logic [15:0] corner_x,
    output logic [15:0] corner_y,
    output logic        busy,
    output logic        done
`ifdef CORNER_COUNT_EN
    ,
    output logic [31:0] corner_count
`endif
);

    localparam logic [15:0] X_LAST = 16'(IMG_W - WIN);
    localparam logic [15:0] Y_LAST = 16'(IMG_H - WIN);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(FIFO_DEPTH + PIPE_LAT + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [15:0] win_x_q, win_x_d;
    logic [15:0] win_y_q, win_y_d;
    logic issue;

    logic [PIPE_LAT-1:0] dv_q;
    logic [15:0] dx_q [PIPE_LAT];
    logic [15:0] dy_q [PIPE_LAT];

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0] head;

    logic [SW-1:0] inflight;
    logic credit_ok;
    logic emerge;
    logic push;
    logic pop;

    // Windows still inside the external pipeline each hold a FIFO credit.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < PIPE_LAT; k++) begin
            inflight = inflight + SW'(dv_q[k]);
        end
    end

    assign credit_ok = (SW'(count_q) + inflight) < SW'(FIFO_DEPTH);

    always_comb begin
        state_d = state_q;
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    win_x_d = '0;
                    win_y_d = '0;
                end
            end
            S_SCAN: begin
                issue = win_ready && credit_ok;
                if (issue) begin
                    if (win_x_q == X_LAST) begin
                        win_x_d = '0;
                        if (win_y_q == Y_LAST) begin
                            win_y_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            win_y_d = win_y_q + 16'd1;
                        end
                    end else begin
                        win_x_d = win_x_q + 16'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight == '0 && count_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            state_q <= state_d;
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dv_q <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                dx_q[k] <= '0;
                dy_q[k] <= '0;
            end
        end else begin
            dv_q[0] <= issue;
            dx_q[0] <= win_x_q;
            dy_q[0] <= win_y_q;
            for (int k = 1; k < PIPE_LAT; k++) begin
                dv_q[k] <= dv_q[k-1];
                dx_q[k] <= dx_q[k-1];
                dy_q[k] <= dy_q[k-1];
            end
        end
    end

    assign emerge = dv_q[PIPE_LAT-1];
    assign push   = emerge && ($signed(r_in) > $signed(thresh));
    assign pop    = corner_valid && corner_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {dx_q[PIPE_LAT-1], dy_q[PIPE_LAT-1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef CORNER_COUNT_EN
    logic [31:0] ccnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccnt_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            ccnt_q <= '0;
        end else if (push) begin
            ccnt_q <= ccnt_q + 32'd1;
        end
    end

    assign corner_count = ccnt_q;
`endif

    assign head         = mem_q[rd_ptr_q];
    assign corner_valid = (count_q != '0);
    assign corner_x     = corner_valid ? head[31:16] : '0;
    assign corner_y     = corner_valid ? head[15:0] : '0;
    assign win_valid    = issue;
    assign win_x        = win_x_q;
    assign win_y        = win_y_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_corner_scan_ctrl.sv
// Bench for corner_scan_ctrl on an 8x8 frame with 6x6 windows (3x3 origins).
// Checks issue order, credit stalls, corner timing/order and reset behaviour.
module tb_corner_scan_ctrl;

    localparam int P     = 4;
    localparam int D     = 8;
    localparam int NX    = 3;
    localparam int TOTAL = 9;
    localparam int MAXC  = 20000;
    localparam int BOUND = 400;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] thresh;
    logic        win_ready;
    logic        win_valid;
    logic [15:0] win_x, win_y;
    logic [63:0] r_in;
    logic        corner_valid;
    logic        corner_ready;
    logic [15:0] corner_x, corner_y;
    logic        busy, done;
`ifdef CORNER_COUNT_EN
    logic [31:0] corner_count;
`endif

    corner_scan_ctrl #(
        .IMG_W(8), .IMG_H(8), .WIN(6), .PIPE_LAT(P), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .thresh(thresh),
        .win_ready(win_ready), .win_valid(win_valid),
        .win_x(win_x), .win_y(win_y), .r_in(r_in),
        .corner_valid(corner_valid), .corner_ready(corner_ready),
        .corner_x(corner_x), .corner_y(corner_y),
        .busy(busy), .done(done)
`ifdef CORNER_COUNT_EN
        , .corner_count(corner_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit     issued [MAXC];
    bit     push_c [MAXC];
    longint iss_sc [MAXC];
    longint sc [3][3];
    longint th_m;
    int     cq_x[$];
    int     cq_y[$];
    int     cyc = 0;
    int     n_iss, n_pop, pushed_m;
    int     act_iss, act_pop, act_done;
    bit     in_frame, drained_prev, fdone;

    typedef struct {
        longint th;
        int sm, wm, cm, exp_iss, exp_cor;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit wsel(input int m);
        if (m == 0) return 1'b1;
        if (m == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    function automatic bit csel(input int m, input int k);
        if (m == 0) return 1'b1;
        if (m == 1) return $urandom_range(0, 1) == 1;
        return k >= 40;
    endfunction

    // Scores per window for each scenario; corner list follows raster order.
    task automatic fill(input int sm, input longint th);
        cq_x.delete();
        cq_y.delete();
        for (int n = 0; n < TOTAL; n++) begin
            int x, y;
            longint s;
            x = n % NX;
            y = n / NX;
            case (sm)
                0: s = th;
                1: s = (x == 1 && y == 1) ? th + 1 : th;
                2: s = 70000;
                3: s = (x == y) ? th + 1 : th - 1;
                4: s = th + longint'($urandom_range(0, 4)) - 2;
                5: s = (x == 0) ? th + 1 : th;
                6: s = ((x + y) % 2 == 0) ? th + 1 : th - 7;
                default: s = (n >= 7) ? th + 1 : th - 1;
            endcase
            sc[y][x] = s;
            if (s > th) begin
                cq_x.push_back(x);
                cq_y.push_back(y);
            end
        end
    endtask

    task automatic step(input bit st, input bit wr, input bit cr);
        int infl, fifo_m;
        bit exp_wv, exp_done;
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clk);
        reset = 1'b0;
        start = st;
        win_ready = wr;
        corner_ready = cr;
        if (cyc >= P && issued[cyc-P]) r_in = iss_sc[cyc-P];
        else r_in = {$urandom, $urandom};
        if (cyc >= P + 1 && push_c[cyc-P-1]) pushed_m++;
        infl = 0;
        for (int t = cyc - P; t < cyc; t++) begin
            if (t >= 0 && issued[t]) infl++;
        end
        fifo_m = pushed_m - n_pop;
        exp_wv = in_frame && n_iss < TOTAL && wr && (fifo_m + infl < D);
        exp_done = drained_prev;
        #1;
        chk("win_valid", win_valid, exp_wv);
        chk("corner_valid", corner_valid, fifo_m > 0);
        chk("done", done, exp_done);
        chk("busy", busy, in_frame);
        act_iss += int'(win_valid);
        act_done += int'(done);
        if (corner_valid && corner_ready) act_pop++;
        drained_prev = in_frame && !exp_done && n_iss == TOTAL
                       && infl == 0 && fifo_m == 0;
        if (exp_wv) begin
            chk("win_x", win_x, n_iss % NX);
            chk("win_y", win_y, n_iss / NX);
            issued[cyc] = 1'b1;
            iss_sc[cyc] = sc[n_iss/NX][n_iss%NX];
            push_c[cyc] = iss_sc[cyc] > th_m;
            n_iss++;
        end
        if (fifo_m > 0 && n_pop < cq_x.size()) begin
            chk("corner_x", corner_x, cq_x[n_pop]);
            chk("corner_y", corner_y, cq_y[n_pop]);
            if (cr) n_pop++;
        end
        if (exp_done) begin
            in_frame = 1'b0;
            fdone = 1'b1;
        end
        if (st && !in_frame && !exp_done) begin
            in_frame = 1'b1;
            n_iss = 0;
            n_pop = 0;
            pushed_m = 0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_corner_valid", corner_valid, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_corner_x", corner_x, 0);
        chk("rst_corner_y", corner_y, 0);
        for (int t = cyc - P - 1; t <= cyc; t++) begin
            if (t >= 0) begin
                issued[t] = 1'b0;
                push_c[t] = 1'b0;
            end
        end
        in_frame = 1'b0;
        drained_prev = 1'b0;
        pushed_m = 0;
        n_pop = 0;
        n_iss = 0;
        cyc++;
    endtask

    task automatic run_frame(input longint th, input int sm, input int wm,
                             input int cm, input int exp_iss, input int exp_cor);
        int k;
        int ncor;
        th_m = th;
        thresh = th;
        fill(sm, th);
        ncor = (exp_cor < 0) ? cq_x.size() : exp_cor;
        act_iss = 0;
        act_pop = 0;
        act_done = 0;
        fdone = 1'b0;
        step(1'b1, wsel(wm), csel(cm, 0));
        k = 1;
        while (!fdone && k < BOUND) begin
            if (cm == 2 && k == 40) chk("credit_stall_issues", act_iss, D);
            step(1'b0, wsel(wm), csel(cm, k));
            k++;
        end
        if (!fdone) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_timeout: got no done in %0d cycles, required done", k);
        end
        chk("frame_issues", act_iss, exp_iss);
        chk("frame_corners", act_pop, ncor);
        chk("frame_done_pulses", act_done, 1);
`ifdef CORNER_COUNT_EN
        step(1'b0, 1'b1, 1'b1);
        chk("corner_count", corner_count, ncor);
`endif
    endtask

    initial begin
        vec_t tbl [8];
        int k;
        tbl[0] = '{longint'(65536), 0, 0, 0, 9, 0};
        tbl[1] = '{longint'(65536), 1, 0, 0, 9, 1};
        tbl[2] = '{longint'(65536), 2, 0, 2, 9, 9};
        tbl[3] = '{longint'(-5), 5, 1, 0, 9, 3};
        tbl[4] = '{longint'(0), 3, 2, 1, 9, 3};
        tbl[5] = '{longint'(1000), 6, 0, 0, 9, 5};
        tbl[6] = '{longint'(-1000), 6, 2, 1, 9, 5};
        tbl[7] = '{-64'sd9000000000, 1, 1, 1, 9, 1};

        reset = 1'b1;
        start = 1'b0;
        thresh = '0;
        win_ready = 1'b0;
        corner_ready = 1'b0;
        r_in = '0;
        th_m = 0;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_frame(tbl[i].th, tbl[i].sm, tbl[i].wm, tbl[i].cm,
                      tbl[i].exp_iss, tbl[i].exp_cor);
        end

        // Reset in DRAIN with the last two (corner) windows still in flight.
        th_m = 65536;
        thresh = 64'd65536;
        fill(7, th_m);
        act_pop = 0;
        step(1'b1, 1'b1, 1'b1);
        k = 0;
        while (n_iss < TOTAL - 1 && k < 100) begin
            step(1'b0, 1'b1, 1'b1);
            k++;
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        k = 0;
        while (n_iss < TOTAL && k < 20) begin
            step(1'b0, 1'b1, 1'b1);
            k++;
        end
        chk("pre_reset_issues", n_iss, TOTAL);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        chk("post_reset_pops", act_pop, 0);
        run_frame(65536, 1, 0, 0, 9, 1);

        for (int i = 0; i < 12; i++) begin
            run_frame({$urandom, $urandom}, 4, 2, 1, 9, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
